// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the interrupt controller: register map,
// default vectors and the RUN/HANDLER state type.
package irq_ctrl_pkg;

   // Register byte offsets on the small configuration bus
   localparam logic [3:0] OFF_CTRL  = 4'h0;
   localparam logic [3:0] OFF_MASK  = 4'h4;
   localparam logic [3:0] OFF_PEND  = 4'h8;
   localparam logic [3:0] OFF_CAUSE = 4'hC;

   // Default redirect targets
   localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
   localparam logic [31:0] DEF_IRQ_BASE  = 32'h8000_0008;

   // Largest supported channel count (ids fit in 5 bits with room to spare)
   localparam int MAX_IRQ = 16;

   // Controller state: RUN accepts exceptions, HANDLER blocks them until eret
   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_HANDLER = 1'b1
   } state_t;

   // Vector of a given channel: base plus one word per channel
   function automatic logic [31:0] irq_vector(input logic [31:0] base, input logic [4:0] id);
      return base + {25'b0, id, 2'b00};
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest-index set request bit and
// whether any bit is set at all.
module irq_prio_enc #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   output logic [4:0]   id,
   output logic         valid
);

   // Scan from the top down so the lowest set index is the last one written
   always_comb begin
      id    = '0;
      valid = |req;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) id = 5'(i);
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt / exception controller. Edge-detects level interrupt lines into
// a pending register, arbitrates illegal-opcode over interrupts (lowest
// channel first), redirects the PC combinationally, saves EPC/CAUSE and
// blocks further entries until eret. Illegal opcodes that cannot be taken
// set a sticky double_fault flag.
//
// Bus handshake: a register access is a single-cycle strobe. sel=1 selects
// the block; rdata is combinational from addr while sel=1 (0 otherwise);
// sel=1 with wr=1 commits wdata at the next rising clk edge. There is no
// ready/wait state: every access completes in the cycle it is presented.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int          N_IRQ     = 4,
   parameter logic [31:0] ILLOP_VEC = DEF_ILLOP_VEC,
   parameter logic [31:0] IRQ_BASE  = DEF_IRQ_BASE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic             illop,
   input  logic [31:0]      pc,
   input  logic [31:0]      pc_plus4,
   input  logic             eret,
   input  logic             sel,
   input  logic             wr,
   input  logic [3:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             take,
   output logic [31:0]      vector,
   output logic [31:0]      epc,
   output logic             double_fault
);

   state_t             state;
   state_t             state_nxt;
   logic               ie;
   logic [N_IRQ-1:0]   mask;
   logic [N_IRQ-1:0]   pend;
   logic [N_IRQ-1:0]   irq_q;
   logic [N_IRQ-1:0]   rise;
   logic [N_IRQ-1:0]   clr_take;
   logic [N_IRQ-1:0]   clr_w1c;
   logic [4:0]         id;
   logic               id_valid;
   logic               take_c;
   logic               take_irq;
   logic               wr_en;
   logic [31:0]        epc_q;
   logic [31:0]        cause_q;
   logic               df_q;
   logic               unused_wdata;

   // Only the low N_IRQ bits of wdata carry register content
   assign unused_wdata = &{1'b0, wdata[31:N_IRQ]};

   // Lowest pending, unmasked channel
   irq_prio_enc #(.N(N_IRQ)) u_prio (
      .req   (pend & mask),
      .id    (id),
      .valid (id_valid)
   );

   assign rise  = irq_in & ~irq_q;
   assign wr_en = sel & wr;

   // Next-state and redirect decision; PCs in the upper half are never redirected
   always_comb begin
      state_nxt = state;
      take_c    = 1'b0;
      case (state)
         ST_RUN: begin
            if (!pc[31] && (illop || (ie && id_valid))) begin
               take_c    = 1'b1;
               state_nxt = ST_HANDLER;
            end
         end
         ST_HANDLER: begin
            if (eret) state_nxt = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // Outputs are forced quiet while reset is held
   assign take     = reset & take_c;
   assign take_irq = take & ~illop;
   assign vector   = !take  ? 32'h0 :
                     illop  ? ILLOP_VEC : irq_vector(IRQ_BASE, id);
   assign epc          = epc_q;
   assign double_fault = df_q;

   // Pending-bit clear sources: the channel being taken, and software W1C
   always_comb begin
      clr_take = '0;
      clr_w1c  = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         clr_take[i] = take_irq && (id == 5'(i));
      end
      if (wr_en && addr == OFF_PEND) clr_w1c = wdata[N_IRQ-1:0];
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_RUN;
      else        state <= state_nxt;
   end

   // Interrupt edge capture; a fresh rising edge beats any clear on the same edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_q <= '0;
         pend  <= '0;
      end else begin
         irq_q <= irq_in;
         pend  <= (pend & ~clr_take & ~clr_w1c) | rise;
      end
   end

   // Software-writable control: enable and mask
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ie   <= 1'b0;
         mask <= '0;
      end else if (wr_en) begin
         if (addr == OFF_CTRL) ie   <= wdata[0];
         if (addr == OFF_MASK) mask <= wdata[N_IRQ-1:0];
      end
   end

   // Exception entry bookkeeping and sticky double-fault detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         epc_q   <= '0;
         cause_q <= '0;
         df_q    <= 1'b0;
      end else begin
         if (take) begin
            epc_q   <= illop ? pc_plus4 : pc;
            cause_q <= {illop, 26'b0, (illop ? 5'b0 : id)};
         end
         if (illop && (state == ST_HANDLER || pc[31])) df_q <= 1'b1;
      end
   end

   // Register read mux; unused bits and unused offsets read as zero
   always_comb begin
      rdata = '0;
      if (reset && sel) begin
         case (addr)
            OFF_CTRL:  rdata[0]         = ie;
            OFF_MASK:  rdata[N_IRQ-1:0] = mask;
            OFF_PEND:  rdata[N_IRQ-1:0] = pend;
            OFF_CAUSE: rdata            = cause_q;
            default:   rdata            = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations, plus a
// behavioural model compared against the DUT on every falling clock edge.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  irq_in = '0;
   logic        illop = 1'b0;
   logic [31:0] pc = 32'h100;
   logic [31:0] pc_plus4 = 32'h104;
   logic        eret = 1'b0;
   logic        sel = 1'b0;
   logic        wr = 1'b0;
   logic [3:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        take;
   logic [31:0] vector;
   logic [31:0] epc;
   logic        double_fault;

   int n_tests = 0;
   int n_fail  = 0;
   bit checking = 1'b0;

   irq_ctrl dut (
      .clk(clk), .reset(reset), .irq_in(irq_in), .illop(illop),
      .pc(pc), .pc_plus4(pc_plus4), .eret(eret),
      .sel(sel), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
      .take(take), .vector(vector), .epc(epc), .double_fault(double_fault)
   );

   // clock
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit          m_in_handler;
   bit          m_ie;
   logic [3:0]  m_mask, m_pend, m_prev;
   logic [31:0] m_epc, m_cause;
   bit          m_df;

   task automatic model_reset();
      m_in_handler = 0; m_ie = 0; m_mask = 0; m_pend = 0; m_prev = 0;
      m_epc = 0; m_cause = 0; m_df = 0;
   endtask

   function automatic int lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic bit exp_take();
      if (!reset || m_in_handler || pc[31]) return 0;
      return illop || (m_ie && (lowest(m_pend & m_mask) >= 0));
   endfunction

   function automatic logic [31:0] exp_vector();
      if (illop) return 32'h8000_0004;
      return 32'h8000_0008 + 32'(4 * lowest(m_pend & m_mask));
   endfunction

   function automatic logic [31:0] exp_rdata();
      if (!reset || !sel) return 0;
      case (addr)
         4'h0: return {31'b0, m_ie};
         4'h4: return {28'b0, m_mask};
         4'h8: return {28'b0, m_pend};
         4'hC: return m_cause;
         default: return 0;
      endcase
   endfunction

   initial model_reset();
   always @(negedge reset) model_reset();

   // Advance the model at each active edge using the inputs held across it
   always @(posedge clk) begin : model_step
      bit          t, was_h;
      int          k;
      logic [3:0]  np;
      if (!reset) model_reset();
      else begin
         was_h = m_in_handler;
         t     = exp_take();
         k     = lowest(m_pend & m_mask);
         np    = m_pend;
         if (t) begin
            m_in_handler = 1;
            if (illop) begin
               m_epc = pc_plus4; m_cause = 32'h8000_0000;
            end else begin
               m_epc = pc; m_cause = 32'(k); np[k] = 1'b0;
            end
         end else if (was_h && eret) m_in_handler = 0;
         if (illop && (was_h || pc[31])) m_df = 1;
         if (sel && wr) begin
            case (addr)
               4'h0: m_ie = wdata[0];
               4'h4: m_mask = wdata[3:0];
               4'h8: np = np & ~wdata[3:0];
               default: ;
            endcase
         end
         m_pend = np | (irq_in & ~m_prev);
         m_prev = irq_in;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (checking) begin
         check("cmp_take", {31'b0, take}, {31'b0, exp_take()});
         if (exp_take()) check("cmp_vector", vector, exp_vector());
         check("cmp_epc", epc, m_epc);
         check("cmp_df", {31'b0, double_fault}, {31'b0, m_df});
         check("cmp_rdata", rdata, exp_rdata());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      sel = 1; wr = 1; addr = a; wdata = d;
      tick();
      sel = 0; wr = 0; wdata = 0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      sel = 1; wr = 0; addr = a;
      #1 d = rdata;
      sel = 0;
   endtask

   // watchdog
   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "timeout");
   end

   // ---------------- directed scenarios ----------------
   initial begin : stim
      logic [31:0] d;
      // reset state: outputs quiet even with illop and a read presented
      illop = 1; sel = 1; addr = 4'hC;
      #2;
      check("rst_take", {31'b0, take}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      illop = 0; sel = 0;
      tick(); tick();
      reset = 1;
      checking = 1;
      check("rst_epc", epc, 32'h0);
      check("rst_df", {31'b0, double_fault}, 32'h0);
      bus_read(4'h0, d); check("rst_ctrl", d, 32'h0);
      bus_read(4'h4, d); check("rst_mask", d, 32'h0);
      bus_read(4'h8, d); check("rst_pend", d, 32'h0);

      // irq entry on channel 2
      bus_write(4'h4, 32'hF);
      bus_write(4'h0, 32'h1);
      irq_in = 4'b0100;
      tick();
      check("irq2_take", {31'b0, take}, 32'h1);
      check("irq2_vector", vector, 32'h8000_0010);
      tick();
      check("irq2_epc", epc, 32'h100);
      bus_read(4'h8, d); check("irq2_pend_clr", d, 32'h0);
      check("irq2_cause", dut.cause_q, 32'h2);

      // new edge while in handler stays pending, then taken after eret
      irq_in = 4'b0110;
      tick();
      check("hdl_no_take", {31'b0, take}, 32'h0);
      bus_read(4'h8, d); check("hdl_pend", d, 32'h2);
      eret = 1; tick(); eret = 0;
      check("eret_take", {31'b0, take}, 32'h1);
      check("eret_vector", vector, 32'h8000_000C);
      tick();
      eret = 1; tick(); eret = 0;
      irq_in = 4'b0000; tick();

      // illegal opcode outranks a pending interrupt
      bus_write(4'h0, 32'h0);
      irq_in = 4'b0001; tick(); irq_in = 4'b0000;
      illop = 1; pc = 32'h40; pc_plus4 = 32'h44;
      #1;
      check("illop_take", {31'b0, take}, 32'h1);
      check("illop_vector", vector, 32'h8000_0004);
      bus_write(4'h0, 32'h1);
      illop = 0; pc = 32'h100; pc_plus4 = 32'h104;
      check("illop_epc", epc, 32'h44);
      bus_read(4'hC, d); check("illop_cause", d, 32'h8000_0000);
      bus_read(4'h8, d); check("illop_pend_kept", d, 32'h1);
      // read-only and unmapped offsets ignore writes
      bus_write(4'hC, 32'h1234_5678);
      bus_write(4'h2, 32'hFFFF_FFFF);
      bus_read(4'hC, d); check("cause_ro", d, 32'h8000_0000);
      bus_read(4'h4, d); check("mask_kept", d, 32'hF);
      bus_read(4'h0, d); check("ctrl_kept", d, 32'h1);
      bus_write(4'h0, 32'h0);
      eret = 1; tick(); eret = 0;
      bus_write(4'h8, 32'h1);
      bus_read(4'h8, d); check("pend_w1c", d, 32'h0);

      // illop from the upper half of the address space: double fault
      pc = 32'h8000_0100; illop = 1;
      #1 check("df_no_take", {31'b0, take}, 32'h0);
      tick();
      illop = 0; pc = 32'h100;
      check("df_set", {31'b0, double_fault}, 32'h1);
      repeat (3) tick();
      check("df_sticky", {31'b0, double_fault}, 32'h1);

      // masked edge pends without redirect; set beats simultaneous W1C
      bus_write(4'h4, 32'h0);
      bus_write(4'h0, 32'h1);
      irq_in = 4'b1000; tick();
      bus_read(4'h8, d); check("masked_pend", d, 32'h8);
      check("masked_no_take", {31'b0, take}, 32'h0);
      irq_in = 4'b0000; tick();
      irq_in = 4'b1000;
      bus_write(4'h8, 32'h8);
      bus_read(4'h8, d); check("set_beats_w1c", d, 32'h8);
      bus_write(4'h8, 32'h8);
      bus_read(4'h8, d); check("w1c_no_edge", d, 32'h0);

      // asynchronous reset in the middle of a handler
      bus_write(4'h4, 32'hF);
      irq_in = 4'b0010; tick();
      check("pre_rst_take", {31'b0, take}, 32'h1);
      tick();
      check("pre_rst_epc", epc, 32'h100);
      #2 reset = 0;
      #1;
      sel = 1; addr = 4'h8;
      #1;
      check("async_take", {31'b0, take}, 32'h0);
      check("async_vector", vector, 32'h0);
      check("async_epc", epc, 32'h0);
      check("async_df", {31'b0, double_fault}, 32'h0);
      check("async_rdata", rdata, 32'h0);
      sel = 0;
      tick();
      reset = 1;
      illop = 1; pc = 32'h200; pc_plus4 = 32'h204;
      #1 check("post_rst_run", {31'b0, take}, 32'h1);
      tick();
      illop = 0; pc = 32'h100; pc_plus4 = 32'h104;
      check("post_rst_epc", epc, 32'h204);
      check("post_rst_df", {31'b0, double_fault}, 32'h0);
      eret = 1; tick(); eret = 0;
      tick();

      checking = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
